// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: debounced runtime video-mode selector that mutes video and restarts timing on frame boundaries.
// Optional feature macro VIDEO_MODE_LOCK_EN: mode_lock blocks mode acceptance while in RUN.
module video_mode_ctrl #(
  parameter int unsigned NUM_MODES     = 3,
  parameter int unsigned MODE_W        = 2,
  parameter int unsigned DEFAULT_MODE  = 1,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter bit          VSYNC_POL     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        config_data,
  input  logic              vsync,
  input  logic              mode_lock,
  output logic [MODE_W-1:0] mode_sel,
  output logic              timing_restart,
  output logic              video_mute,
  output logic              mode_changed,
  output logic              busy,
  output logic              bad_mode
);

  localparam int unsigned STB_W = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_FRAMES + 1);
  localparam logic [STB_W-1:0]  STABLE_MAX = STB_W'(STABLE_FRAMES);
  localparam logic [SET_W-1:0]  SETTLE_MAX = SET_W'(SETTLE_FRAMES);
  localparam logic [MODE_W-1:0] DEF_MODE   = MODE_W'(DEFAULT_MODE);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MUTE   = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_sel_q, mode_sel_d;
  logic [MODE_W-1:0] cand_q, cand_d;
  logic [STB_W-1:0]  stable_q, stable_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              vsync_q;
  logic              frame_start_q, frame_start_d;
  logic              mute_q, mute_d;
  logic              restart_q, restart_d;
  logic              changed_q, changed_d;
  logic              bad_q, bad_d;
  logic              first_q, first_d;

  logic [MODE_W-1:0] req;
  logic              req_bad;
  logic              lock_hold;
  logic              unused_in;

  assign req     = config_data[MODE_W-1:0];
  assign req_bad = (32'(req) >= NUM_MODES);

`ifdef VIDEO_MODE_LOCK_EN
  assign lock_hold = mode_lock;
  assign unused_in = ^config_data;
`else
  assign lock_hold = 1'b0;
  assign unused_in = ^{config_data, mode_lock};
`endif

  always_comb begin
    frame_start_d = VSYNC_POL ? (vsync & ~vsync_q) : (~vsync & vsync_q);
  end

  always_comb begin
    state_d    = state_q;
    mode_sel_d = mode_sel_q;
    cand_d     = cand_q;
    stable_d   = stable_q;
    settle_d   = settle_q;
    mute_d     = mute_q;
    restart_d  = 1'b0;
    changed_d  = 1'b0;
    bad_d      = bad_q;
    first_d    = first_q;

    case (state_q)
      RUN: begin
        if (frame_start_q) begin
          if (req_bad) begin
            bad_d    = 1'b1;
            stable_d = '0;
          end else if (req != cand_q) begin
            cand_d   = req;
            stable_d = STB_W'(1);
          end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 1'b1;
          end
          // Acceptance uses the freshly updated filter so a saturated, different
          // candidate (e.g. after lock release) switches on this frame start.
          if (!lock_hold && (stable_d == STABLE_MAX) && (cand_d != mode_sel_q)) begin
            state_d = MUTE;
            mute_d  = 1'b1;
          end
        end
      end
      MUTE: begin
        if (frame_start_q) begin
          state_d   = SWITCH;
          restart_d = 1'b1;
        end
      end
      SWITCH: begin
        mode_sel_d = cand_q;
        settle_d   = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (frame_start_q) begin
          settle_d = settle_q + 1'b1;
          if (settle_d == SETTLE_MAX) begin
            state_d   = RUN;
            mute_d    = 1'b0;
            changed_d = ~first_q;
            first_d   = 1'b0;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SETTLE;
      mode_sel_q    <= DEF_MODE;
      cand_q        <= DEF_MODE;
      stable_q      <= '0;
      settle_q      <= '0;
      vsync_q       <= VSYNC_POL;
      frame_start_q <= 1'b0;
      mute_q        <= 1'b1;
      restart_q     <= 1'b0;
      changed_q     <= 1'b0;
      bad_q         <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      mode_sel_q    <= mode_sel_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      settle_q      <= settle_d;
      vsync_q       <= vsync;
      frame_start_q <= frame_start_d;
      mute_q        <= mute_d;
      restart_q     <= restart_d;
      changed_q     <= changed_d;
      bad_q         <= bad_d;
      first_q       <= first_d;
    end
  end

  assign mode_sel       = mode_sel_q;
  assign timing_restart = restart_q;
  assign video_mute     = mute_q;
  assign mode_changed   = changed_q;
  assign busy           = (state_q != RUN);
  assign bad_mode       = bad_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed self-checking bench for video_mode_ctrl; frames are 10 clocks with a 4-clock active-high vsync.
module tb_video_mode_ctrl;

  localparam int FRAME_LEN = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic       mode_lock;
  logic [7:0] config_data;
  logic [1:0] mode_sel;
  logic       timing_restart, video_mute, mode_changed, busy, bad_mode;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned restart_seen, changed_seen, mute_seen;
  int          restart_pos;

  always #5 clock = ~clock;

  video_mode_ctrl #(
    .NUM_MODES(3), .MODE_W(2), .DEFAULT_MODE(1),
    .STABLE_FRAMES(2), .SETTLE_FRAMES(2), .VSYNC_POL(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .config_data(config_data), .vsync(vsync),
    .mode_lock(mode_lock), .mode_sel(mode_sel), .timing_restart(timing_restart),
    .video_mute(video_mute), .mode_changed(mode_changed), .busy(busy), .bad_mode(bad_mode)
  );

  task automatic clear_mon();
    restart_seen = 0; changed_seen = 0; mute_seen = 0; restart_pos = -1;
  endtask

  // One frame: vsync rises at step 0; outputs are sampled on every falling edge.
  task automatic frame();
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clock);
      vsync = (i < 4);
      if (timing_restart === 1'b1) begin restart_seen++; restart_pos = i; end
      if (mode_changed === 1'b1) changed_seen++;
      if (video_mute === 1'b1) mute_seen++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vsync = 1'b0; config_data = 8'd1; mode_lock = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (mode_sel !== 2'd1) begin n_err++; $display("FAIL rst_mode_sel: got %0d expected 1", mode_sel); end
    n_cmp++; if (video_mute !== 1'b1) begin n_err++; $display("FAIL rst_mute: got %b expected 1", video_mute); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b expected 1", busy); end
    n_cmp++; if ({timing_restart, mode_changed, bad_mode} !== 3'b000) begin n_err++; $display("FAIL rst_pulses: got %b expected 000", {timing_restart, mode_changed, bad_mode}); end
    reset_n = 1'b1;
    clear_mon();
    frame();
    n_cmp++; if (video_mute !== 1'b1) begin n_err++; $display("FAIL rst_settle1_mute: got %b expected 1", video_mute); end
    frame();
    n_cmp++; if (video_mute !== 1'b0) begin n_err++; $display("FAIL rst_exit_mute: got %b expected 0", video_mute); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_exit_busy: got %b expected 0", busy); end
    n_cmp++; if (changed_seen !== 0) begin n_err++; $display("FAIL rst_exit_changed: got %0d pulses expected 0", changed_seen); end
    n_cmp++; if (restart_seen !== 0) begin n_err++; $display("FAIL rst_exit_restart: got %0d pulses expected 0", restart_seen); end
  endtask

  task automatic test_switch();
    config_data = 8'd2;
    clear_mon();
    frame();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sw_f1_busy: got %b expected 0", busy); end
    frame();
    n_cmp++; if ({busy, video_mute} !== 2'b11) begin n_err++; $display("FAIL sw_f2_mute: got %b expected 11", {busy, video_mute}); end
    n_cmp++; if (mode_sel !== 2'd1) begin n_err++; $display("FAIL sw_f2_mode: got %0d expected 1", mode_sel); end
    n_cmp++; if (restart_seen !== 0) begin n_err++; $display("FAIL sw_f2_restart: got %0d expected 0", restart_seen); end
    frame();
    n_cmp++; if (restart_seen !== 1) begin n_err++; $display("FAIL sw_restart_cnt: got %0d expected 1", restart_seen); end
    n_cmp++; if (restart_pos !== 2) begin n_err++; $display("FAIL sw_restart_pos: got %0d expected 2", restart_pos); end
    n_cmp++; if (mode_sel !== 2'd2) begin n_err++; $display("FAIL sw_f3_mode: got %0d expected 2", mode_sel); end
    frame();
    n_cmp++; if (video_mute !== 1'b1) begin n_err++; $display("FAIL sw_f4_mute: got %b expected 1", video_mute); end
    n_cmp++; if (changed_seen !== 0) begin n_err++; $display("FAIL sw_f4_changed: got %0d expected 0", changed_seen); end
    frame();
    n_cmp++; if ({busy, video_mute} !== 2'b00) begin n_err++; $display("FAIL sw_f5_run: got %b expected 00", {busy, video_mute}); end
    n_cmp++; if (changed_seen !== 1) begin n_err++; $display("FAIL sw_changed_cnt: got %0d expected 1", changed_seen); end
  endtask

  task automatic test_glitch();
    clear_mon();
    config_data = 8'd1; frame();
    config_data = 8'd2; frame(); frame(); frame();
    n_cmp++; if (restart_seen !== 0) begin n_err++; $display("FAIL gl_restart: got %0d expected 0", restart_seen); end
    n_cmp++; if (mute_seen !== 0) begin n_err++; $display("FAIL gl_mute_cycles: got %0d expected 0", mute_seen); end
    n_cmp++; if (mode_sel !== 2'd2) begin n_err++; $display("FAIL gl_mode: got %0d expected 2", mode_sel); end
  endtask

  task automatic test_invalid();
    n_cmp++; if (bad_mode !== 1'b0) begin n_err++; $display("FAIL inv_pre_bad: got %b expected 0", bad_mode); end
    clear_mon();
    config_data = 8'd3;
    repeat (5) frame();
    n_cmp++; if (bad_mode !== 1'b1) begin n_err++; $display("FAIL inv_bad: got %b expected 1", bad_mode); end
    n_cmp++; if (mode_sel !== 2'd2) begin n_err++; $display("FAIL inv_mode: got %0d expected 2", mode_sel); end
    config_data = 8'd2;
    repeat (3) frame();
    n_cmp++; if (bad_mode !== 1'b1) begin n_err++; $display("FAIL inv_sticky: got %b expected 1", bad_mode); end
    n_cmp++; if ((restart_seen !== 0) || (mute_seen !== 0)) begin n_err++; $display("FAIL inv_quiet: got restart=%0d mute=%0d expected 0/0", restart_seen, mute_seen); end
  endtask

  task automatic test_reset_mid_settle();
    config_data = 8'd0;
    clear_mon();
    repeat (4) frame();
    n_cmp++; if ({mode_sel, busy} !== {2'd0, 1'b1}) begin n_err++; $display("FAIL mid_pre: got mode=%0d busy=%b expected 0/1", mode_sel, busy); end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (mode_sel !== 2'd1) begin n_err++; $display("FAIL mid_rst_mode: got %0d expected 1", mode_sel); end
    n_cmp++; if ({video_mute, busy} !== 2'b11) begin n_err++; $display("FAIL mid_rst_mute_busy: got %b expected 11", {video_mute, busy}); end
    n_cmp++; if (bad_mode !== 1'b0) begin n_err++; $display("FAIL mid_rst_bad: got %b expected 0", bad_mode); end
    config_data = 8'd1;
    @(negedge clock);
    reset_n = 1'b1;
    clear_mon();
    frame(); frame();
    n_cmp++; if ({mode_sel, video_mute, busy} !== {2'd1, 2'b00}) begin n_err++; $display("FAIL mid_exit: got mode=%0d mute=%b busy=%b expected 1/0/0", mode_sel, video_mute, busy); end
    n_cmp++; if (changed_seen !== 0) begin n_err++; $display("FAIL mid_exit_changed: got %0d expected 0", changed_seen); end
  endtask

  task automatic test_back_to_back();
    config_data = 8'd2;
    clear_mon();
    frame(); frame();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    config_data = 8'd0;
    frame();
    n_cmp++; if (mode_sel !== 2'd2) begin n_err++; $display("FAIL b2b_first_mode: got %0d expected 2", mode_sel); end
    frame(); frame();
    n_cmp++; if ({busy, changed_seen} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL b2b_first_done: got busy=%b changed=%0d expected 0/1", busy, changed_seen); end
    clear_mon();
    frame();
    n_cmp++; if ((busy !== 1'b0) || (restart_seen !== 0)) begin n_err++; $display("FAIL b2b_requalify: got busy=%b restart=%0d expected 0/0", busy, restart_seen); end
    frame();
    n_cmp++; if (video_mute !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got %b expected 1", video_mute); end
    repeat (3) frame();
    n_cmp++; if (mode_sel !== 2'd0) begin n_err++; $display("FAIL b2b_second_mode: got %0d expected 0", mode_sel); end
    n_cmp++; if ({restart_seen, changed_seen} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL b2b_second_pulses: got restart=%0d changed=%0d expected 1/1", restart_seen, changed_seen); end
  endtask

`ifdef VIDEO_MODE_LOCK_EN
  task automatic test_lock();
    mode_lock = 1'b1; config_data = 8'd1;
    clear_mon();
    repeat (4) frame();
    n_cmp++; if ({busy, restart_seen} !== {1'b0, 32'd0}) begin n_err++; $display("FAIL lock_hold: got busy=%b restart=%0d expected 0/0", busy, restart_seen); end
    n_cmp++; if (mode_sel !== 2'd0) begin n_err++; $display("FAIL lock_mode: got %0d expected 0", mode_sel); end
    mode_lock = 1'b0;
    frame();
    n_cmp++; if ({busy, video_mute} !== 2'b11) begin n_err++; $display("FAIL lock_release: got %b expected 11", {busy, video_mute}); end
    mode_lock = 1'b1;
    repeat (3) frame();
    n_cmp++; if ({mode_sel, busy} !== {2'd1, 1'b0}) begin n_err++; $display("FAIL lock_finish: got mode=%0d busy=%b expected 1/0", mode_sel, busy); end
    mode_lock = 1'b0;
  endtask
`else
  task automatic test_lock();
    mode_lock = 1'b1; config_data = 8'd1;
    clear_mon();
    frame(); frame();
    n_cmp++; if ({busy, video_mute} !== 2'b11) begin n_err++; $display("FAIL nolock_accept: got %b expected 11", {busy, video_mute}); end
    repeat (3) frame();
    n_cmp++; if ({mode_sel, busy} !== {2'd1, 1'b0}) begin n_err++; $display("FAIL nolock_finish: got mode=%0d busy=%b expected 1/0", mode_sel, busy); end
    mode_lock = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_switch();
    test_glitch();
    test_invalid();
    test_reset_mid_settle();
    test_back_to_back();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
